mutation_engine: RTL and testbench

//  Responder side of the GA controller's mut_start/mut_done handshake.
//  On mut_start it captures the selected population and walks it one individual per cycle.
//  For each individual it applies at most one LFSR-driven bit flip.
//  It returns the result on mut_pop and signals mut_done; the controller feeds mut_pop back as its next population.

---
 rtl/ga_pkg.sv | 22 ++
 rtl/mutation_engine_lfsr16.sv | 25 ++
 rtl/mutation_engine.sv | 100 ++++++++++
 tb/tb_mutation_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared GA definitions: population geometry, LFSR polynomial and mutation FSM encoding.
// Also used by the state, selection and init blocks.
package ga_pkg;

    localparam int          IND_BITS  = 75;
    localparam int          POP_SIZE  = 100;
    localparam int          POP_BITS  = IND_BITS * POP_SIZE;
    localparam int          IDX_W     = $clog2(POP_SIZE);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUTATE = 2'd1,
        DONE   = 2'd2
    } mut_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/mutation_engine_lfsr16.sv
// 16-bit Galois LFSR that advances only when en is high; reset loads seed.
// Shared with the selection unit, so it carries no mutation-specific logic.
module lfsr16
    import ga_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mutation_engine.sv
// Mutation responder: captures a population on mut_start, then walks it one
// individual per cycle applying at most one LFSR-chosen bit flip to each.
module mutation_engine
    import ga_pkg::*;
#(
    parameter logic [7:0]  MUT_RATE = 8'd32,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter bit          ELITE    = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mut_start,
    input  logic [POP_BITS-1:0] population,
    output logic [POP_BITS-1:0] mut_pop,
    output logic                mut_done,
    output logic                mut_busy
);

    localparam logic [6:0]          IND_BITS_P = 7'(IND_BITS);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(POP_SIZE - 1);
    localparam logic [IND_BITS-1:0] ONE_HOT0   = IND_BITS'(1);

    mut_state_e          r_state;
    mut_state_e          w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [POP_BITS-1:0] r_pop;
    logic                r_done;

    logic [15:0]         w_lfsr;
    logic                w_lfsr_en;
    logic [6:0]          w_pos;
    logic                w_flip;
    logic                w_last;
    logic [IND_BITS-1:0] w_flip_mask;
    int                  w_base;

    // The LFSR steps once per processed individual, flip or not.
    assign w_lfsr_en = (r_state == MUTATE);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_lfsr_en),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    always_comb begin
        w_pos       = w_lfsr[6:0];
        w_last      = (r_idx == LAST_IDX);
        w_base      = int'(r_idx) * IND_BITS;
        w_flip      = (w_lfsr[15:8] < MUT_RATE) && (w_pos < IND_BITS_P)
                      && !(ELITE && (r_idx == '0));
        w_flip_mask = w_flip ? (ONE_HOT0 << w_pos) : '0;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (mut_start) w_next_state = MUTATE;
            MUTATE:  if (w_last)    w_next_state = DONE;
            DONE:    if (!mut_start) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_pop   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (mut_start) begin
                        r_pop <= population;
                        r_idx <= '0;
                    end
                end
                MUTATE: begin
                    r_pop[w_base +: IND_BITS] <= r_pop[w_base +: IND_BITS] ^ w_flip_mask;
                    // idx wraps to 0 rather than reaching POP_SIZE.
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) r_done <= 1'b1;
                end
                DONE: begin
                    if (!mut_start) r_done <= 1'b0;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign mut_pop  = r_pop;
    assign mut_done = r_done;
    assign mut_busy = (r_state == MUTATE);

endmodule

// File: tb/tb_mutation_engine.sv
// Directed bench for mutation_engine: a no-mutation instance and a full-rate
// instance checked against an independent LFSR/flip model through a scoreboard.
module tb_mutation_engine;
    import ga_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start0 = 1'b0, start1 = 1'b0;
    logic [POP_BITS-1:0] population0 = '0, population1 = '0;
    logic [POP_BITS-1:0] mut_pop0, mut_pop1;
    logic                done0, busy0, done1, busy1;

    int checks = 0;
    int errors = 0;

    logic [POP_BITS-1:0] exp_q[$];
    logic [15:0]         m_lfsr = 16'hACE1;
    logic [POP_BITS-1:0] alt_pat, s2_ref, cur, held;

    bit mon_en = 1'b0;
    bit done1_prev = 1'b0;
    int mon_rises = 0;
    int mon_viol  = 0;

    always #5 clk = ~clk;

    mutation_engine #(.MUT_RATE(8'd0), .SEED(16'hACE1), .ELITE(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .mut_start(start0), .population(population0),
        .mut_pop(mut_pop0), .mut_done(done0), .mut_busy(busy0)
    );

    mutation_engine #(.MUT_RATE(8'hFF), .SEED(16'hACE1), .ELITE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mut_start(start1), .population(population1),
        .mut_pop(mut_pop1), .mut_done(done1), .mut_busy(busy1)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy1 && done1) mon_viol++;
            if (done1 && !done1_prev) mon_rises++;
        end
        done1_prev = done1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [POP_BITS-1:0] obs,
                           input logic [POP_BITS-1:0] exp);
        int fi = -1;
        for (int i = 0; i < POP_SIZE; i++)
            if (fi < 0 && obs[i*IND_BITS +: IND_BITS] !== exp[i*IND_BITS +: IND_BITS]) fi = i;
        if (fi < 0) fi = 0;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s individual %0d observed %h expected %h", tag, fi,
                   obs[fi*IND_BITS +: IND_BITS], exp[fi*IND_BITS +: IND_BITS]);
        end
    endtask

    // Reference: rate 0xFF, elite on; each individual sees one LFSR value.
    task automatic model_job(input logic [POP_BITS-1:0] pin, input logic [15:0] lin,
                             output logic [POP_BITS-1:0] pout, output logic [15:0] lout);
        logic [15:0] lf;
        int pos;
        lf   = lin;
        pout = pin;
        for (int i = 0; i < POP_SIZE; i++) begin
            pos = int'(lf[6:0]);
            if (lf[15:8] < 8'hFF && pos < IND_BITS && i != 0)
                pout[i*IND_BITS + pos] = ~pout[i*IND_BITS + pos];
            lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        end
        lout = lf;
    endtask

    task automatic start_job1(input logic [POP_BITS-1:0] p);
        logic [POP_BITS-1:0] e;
        population1 = p;
        model_job(p, m_lfsr, e, m_lfsr);
        exp_q.push_back(e);
        start1 = 1'b1;
    endtask

    task automatic sb_compare(input string tag);
        logic [POP_BITS-1:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_pop(tag, mut_pop1, e);
        end
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (!done1 && n < 250) begin
            tick();
            n++;
        end
        chk(tag, 128'(done1), 128'd1);
    endtask

    function automatic logic [POP_BITS-1:0] rand_pop();
        logic [POP_BITS-1:0] p;
        for (int i = 0; i < POP_BITS; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    initial begin
        int rises, busy_cnt, bad, have;
        bit prev;

        for (int i = 0; i < POP_BITS; i++) alt_pat[i] = 1'(i % 2);

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_done1", 128'(done1), 128'd0);
        chk("rst_busy1", 128'(busy1), 128'd0);
        chk_pop("rst_pop1", mut_pop1, '0);
        chk_pop("rst_pop0", mut_pop0, '0);
        rst_n = 1'b1;
        tick();

        // 1: zero rate keeps the population bit-exact, done after 100 edges
        population0 = alt_pat;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("s1_busy", 128'(busy0), 128'd1);
        repeat (99) tick();
        chk("s1_done_early", 128'(done0), 128'd0);
        tick();
        chk("s1_done", 128'(done0), 128'd1);
        chk("s1_busy_off", 128'(busy0), 128'd0);
        chk_pop("s1_pop", mut_pop0, alt_pat);
        tick();
        chk("s1_done_clr", 128'(done0), 128'd0);

        // 2: full rate on all-zero population
        start_job1('0);
        tick();
        start1 = 1'b0;
        wait_done1("s2_wait");
        s2_ref = exp_q[0];
        sb_compare("s2_pop");
        chk("s2_elite", 128'(mut_pop1[IND_BITS-1:0]), 128'd0);
        bad = 0;
        for (int i = 0; i < POP_SIZE; i++)
            if ($countones(mut_pop1[i*IND_BITS +: IND_BITS]) > 1) bad++;
        chk("s2_popcount", 128'(bad), 128'd0);
        tick();
        chk("s2_done_clr", 128'(done1), 128'd0);

        // 3: start held high for 300 cycles runs one job only
        start_job1(rand_pop());
        rises = 0; busy_cnt = 0; bad = 0; have = 0; prev = 1'b0;
        repeat (300) begin
            tick();
            if (busy1) busy_cnt++;
            if (done1 && !prev) rises++;
            if (done1 && have != 0 && mut_pop1 !== held) bad++;
            if (done1 && have == 0) begin
                held = mut_pop1;
                have = 1;
            end
            prev = done1;
        end
        chk("s3_rises", 128'(rises), 128'd1);
        chk("s3_busy_cycles", 128'(busy_cnt), 128'd100);
        chk("s3_stable", 128'(bad), 128'd0);
        chk("s3_done_held", 128'(done1), 128'd1);
        sb_compare("s3_pop");
        start1 = 1'b0;
        tick();
        chk("s3_done_clr", 128'(done1), 128'd0);
        start_job1(rand_pop());
        tick();
        start1 = 1'b0;
        wait_done1("s3b_wait");
        sb_compare("s3b_pop_continued");
        tick();

        // 4: dropping start mid-job does not abort it
        start_job1(rand_pop());
        tick();
        repeat (50) tick();
        start1 = 1'b0;
        repeat (49) tick();
        chk("s4_done_early", 128'(done1), 128'd0);
        tick();
        chk("s4_done", 128'(done1), 128'd1);
        sb_compare("s4_pop");
        tick();
        chk("s4_done_clr", 128'(done1), 128'd0);

        // 5: reset mid-job abandons it and restores SEED
        population1 = '0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (40) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s5_done", 128'(done1), 128'd0);
        chk("s5_busy", 128'(busy1), 128'd0);
        chk_pop("s5_pop", mut_pop1, '0);
        repeat (3) tick();
        chk("s5_idle_busy", 128'(busy1), 128'd0);
        chk("s5_idle_done", 128'(done1), 128'd0);
        m_lfsr = 16'hACE1;
        start_job1('0);
        tick();
        start1 = 1'b0;
        wait_done1("s5_wait");
        sb_compare("s5_pop_rerun");
        chk_pop("s5_vs_s2", mut_pop1, s2_ref);
        tick();

        // 6: 16 back-to-back generations fed back through the model chain
        mon_rises = 0;
        mon_viol  = 0;
        mon_en    = 1'b1;
        cur = rand_pop();
        for (int g = 0; g < 16; g++) begin
            start_job1(cur);
            cur = exp_q[exp_q.size() - 1];
            tick();
            wait_done1("s6_wait");
            sb_compare("s6_pop");
            start1 = 1'b0;
            tick();
            chk("s6_done_clr", 128'(done1), 128'd0);
        end
        tick();
        mon_en = 1'b0;
        chk("s6_rises", 128'(mon_rises), 128'd16);
        chk("s6_busy_done_overlap", 128'(mon_viol), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
